// File: rtl/uart_baud_gen.sv
// Phase-accumulator UART baud generator: oversample and bit ticks with mid-bit resync.
// Optional runtime increment path enabled by UART_BAUD_GEN_INC_WR_EN.
module uart_baud_gen #(
  parameter int unsigned          ACC_WIDTH   = 16,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT = 16'd30000,
  parameter int unsigned          OVS         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     resync,
  input  logic                     inc_wr,
  input  logic [ACC_WIDTH-1:0]     inc_data,
  output logic                     os_tick,
  output logic                     bit_tick,
  output logic [$clog2(OVS)-1:0]   os_cnt,
  output logic [ACC_WIDTH-1:0]     inc_cur,
  output logic                     inc_pend
);

  localparam int unsigned CNT_W = $clog2(OVS);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum_c;
  logic                 carry_c;

  // Carry of the enabled addition; resync suppresses it.
  always_comb begin
    sum_c   = {1'b0, acc} + {1'b0, inc_cur};
    carry_c = en & ~resync & sum_c[ACC_WIDTH];
  end

  // Accumulator, oversample phase and registered tick pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= carry_c;
      bit_tick <= carry_c && (os_cnt == CNT_W'(OVS - 1));
      if (resync) begin
        acc    <= '0;
        os_cnt <= CNT_W'(OVS / 2);
      end else if (en) begin
        acc <= sum_c[ACC_WIDTH-1:0];
        if (carry_c) begin
          os_cnt <= os_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef UART_BAUD_GEN_INC_WR_EN
  logic [ACC_WIDTH-1:0] inc_hold;
  logic                 commit_c;

  assign commit_c = carry_c | resync;

  // Commit uses the value pending before this edge; a coincident write becomes the next pending value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_cur  <= INC_DEFAULT;
      inc_hold <= INC_DEFAULT;
      inc_pend <= 1'b0;
    end else begin
      if (commit_c && inc_pend) begin
        inc_cur  <= inc_hold;
        inc_pend <= 1'b0;
      end
      if (inc_wr) begin
        inc_hold <= inc_data;
        inc_pend <= 1'b1;
      end
    end
  end
`else
  logic unused_inc_c;

  assign inc_cur      = INC_DEFAULT;
  assign inc_pend     = 1'b0;
  assign unused_inc_c = ^{inc_wr, inc_data};
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: arithmetic reference model plus pinned literal expectations.
module tb_uart_baud_gen;

  localparam int unsigned W   = 16;
  localparam int unsigned OVS = 16;
  localparam int unsigned MOD = 1 << W;
  localparam int unsigned INC_DEF = 30000;

  logic         clk = 1'b0;
  logic         rst, en, resync, inc_wr;
  logic [W-1:0] inc_data;
  logic         os_tick, bit_tick;
  logic [3:0]   os_cnt;
  logic [W-1:0] inc_cur;
  logic         inc_pend;

  uart_baud_gen #(.ACC_WIDTH(W), .INC_DEFAULT(16'd30000), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .inc_wr(inc_wr), .inc_data(inc_data),
    .os_tick(os_tick), .bit_tick(bit_tick), .os_cnt(os_cnt), .inc_cur(inc_cur), .inc_pend(inc_pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: accumulator value, tick count within the bit, increments.
  int unsigned m_acc, m_os, m_cur, m_pv;
  bit          m_pend, m_ot, m_bt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_acc = 0; m_os = 0; m_cur = INC_DEF; m_pv = INC_DEF; m_pend = 0; m_ot = 0; m_bt = 0;
  endtask

  task automatic m_step(input bit e, input bit r, input bit w, input int unsigned d);
    bit carry;
    carry = 0;
    m_ot = 0;
    m_bt = 0;
    if (r) begin
      m_acc = 0;
      m_os  = OVS / 2;
    end else if (e) begin
      carry = (m_acc + m_cur) >= MOD;
      m_acc = (m_acc + m_cur) % MOD;
      if (carry) begin
        m_ot = 1;
        m_bt = (m_os == OVS - 1);
        m_os = (m_os + 1) % OVS;
      end
    end
`ifdef UART_BAUD_GEN_INC_WR_EN
    if ((carry || r) && m_pend) begin
      m_cur  = m_pv;
      m_pend = 0;
    end
    if (w) m_pend = 1;
`endif
    m_pv = w ? d : m_pv;
  endtask

  task automatic compare();
    chk("os_tick", os_tick, m_ot);
    chk("bit_tick", bit_tick, m_bt);
    chk("os_cnt", os_cnt, m_os);
    chk("inc_cur", inc_cur, m_cur);
    chk("inc_pend", inc_pend, m_pend);
  endtask

  task automatic step(input bit e, input bit r, input bit w, input int unsigned d);
    en = e; resync = r; inc_wr = w; inc_data = W'(d);
    @(posedge clk);
    m_step(e, r, w, d);
    #1 compare();
  endtask

  // Steps with en=1 until os_tick (bounded); returns the number of steps taken.
  task automatic run_to_tick(input string name, input int bound, output int n);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!os_tick && n < bound);
    if (!os_tick) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int tick_n, bit_n, first_t, second_t, n, ot_n;
    bit e, r, w;
    int unsigned d;

    rst = 1'b0; en = 1'b0; resync = 1'b0; inc_wr = 1'b0; inc_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_os_tick", os_tick, 0);
    chk("rst_bit_tick", bit_tick, 0);
    chk("rst_os_cnt", os_cnt, 0);
    chk("rst_inc_cur", inc_cur, INC_DEF);
    chk("rst_inc_pend", inc_pend, 0);
    #2 rst = 1'b1;

    // Fractional rate from reset: carries at additions 3 and 5, exact long-run count.
    tick_n = 0; bit_n = 0; first_t = 0; second_t = 0;
    for (int i = 1; i <= 10000; i++) begin
      step(1, 0, 0, 0);
      if (os_tick) begin
        tick_n++;
        if (tick_n == 1) first_t = i;
        if (tick_n == 2) second_t = i;
      end
      if (bit_tick) bit_n++;
    end
    chk("first_tick_step", first_t, 3);
    chk("second_tick_step", second_t, 5);
    chk("tick_total", tick_n, 4577);
    chk("bit_total", bit_n, 286);
    chk("os_cnt_after_run", os_cnt, 1);

    // Resync: phase to mid-bit, no tick, bit tick after OVS/2 oversample ticks.
    step(1, 0, 1, 16384);
    step(1, 1, 0, 0);
    chk("resync_os_cnt", os_cnt, 8);
    chk("resync_no_tick", os_tick, 0);
    n = 0; ot_n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
      if (os_tick) ot_n++;
    end while (!bit_tick && n < 200);
    chk("resync_os_ticks_to_bit", ot_n, 8);

`ifdef UART_BAUD_GEN_INC_WR_EN
    chk("resync_commit_inc", inc_cur, 16384);
    chk("resync_cycles_to_bit", n, 32);

    // Increment update waits for the next tick, then ticks every 2 cycles.
    step(1, 0, 0, 0);
    step(1, 0, 1, 32768);
    chk("upd_pend_1", inc_pend, 1);
    chk("upd_cur_hold", inc_cur, 16384);
    run_to_tick("upd_commit", 10, n);
    chk("upd_cur_new", inc_cur, 32768);
    chk("upd_pend_clear", inc_pend, 0);
    run_to_tick("upd_rate", 10, n);
    chk("upd_interval", n, 2);

    // Back-to-back writes: only the last one commits.
    step(0, 0, 1, 16384);
    step(0, 1, 0, 0);
    chk("b2b_base", inc_cur, 16384);
    step(0, 0, 1, 8192);
    step(0, 0, 1, 32768);
    run_to_tick("b2b_commit", 10, n);
    chk("b2b_cur", inc_cur, 32768);

    // Enable drop mid-period freezes the phase.
    step(0, 0, 1, 16384);
    step(0, 1, 0, 0);
    run_to_tick("en_align", 10, n);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    ot_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (os_tick) ot_n++;
    end
    chk("en_frozen_ticks", ot_n, 0);
    run_to_tick("en_resume", 10, n);
    chk("en_resume_steps", n, 2);

    // Zero increment stalls until resync commits the pending value.
    step(1, 0, 1, 0);
    run_to_tick("stall_commit", 10, n);
    chk("stall_cur", inc_cur, 0);
    ot_n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, i == 5, 16384);
      if (os_tick) ot_n++;
    end
    chk("stall_no_ticks", ot_n, 0);
    chk("stall_pend", inc_pend, 1);
    step(1, 1, 0, 0);
    chk("stall_resync_cur", inc_cur, 16384);
    run_to_tick("stall_resume", 10, n);
    chk("stall_resume_steps", n, 4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      e = $urandom_range(0, 99) < 85;
      r = $urandom_range(0, 99) < 3;
      w = $urandom_range(0, 99) < 6;
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 65535);
        1: d = 16384;
        2: d = 32768;
        default: d = 0;
      endcase
      step(e, r, w, d);
    end

    // Async reset between edges while a write is pending and a tick is high.
    step(0, 0, 1, 16384);
    step(1, 1, 0, 0);
    n = 0;
    while (m_acc + m_cur < MOD && n < 20) begin
      step(1, 0, 0, 0);
      n++;
    end
    step(1, 0, 1, 5000);
    chk("pre_arst_tick", os_tick, 1);
`ifdef UART_BAUD_GEN_INC_WR_EN
    chk("pre_arst_pend", inc_pend, 1);
`endif
    #3 rst = 1'b0;
    #1;
    chk("arst_os_tick", os_tick, 0);
    chk("arst_bit_tick", bit_tick, 0);
    chk("arst_os_cnt", os_cnt, 0);
    chk("arst_inc_cur", inc_cur, INC_DEF);
    chk("arst_inc_pend", inc_pend, 0);
    #2 rst = 1'b1;
    m_reset();
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable phase-accumulator baud generator for the UART transmitter and receiver. Each clock, a fractional accumulator adds a runtime-loadable increment. Every carry-out produces an oversample tick (`os_tick`), and every OVS oversample ticks produces a bit tick (`bit_tick`). A resync input realigns the bit phase to mid-bit on a receiver start-bit edge. Increment changes are glitch-free: they are held pending and committed only on a tick boundary.

## Interface
- `ACC_WIDTH`, 16 — accumulator and increment width; tick rate is f_clk·inc/2^ACC_WIDTH.
- `INC_DEFAULT`, 16'd30000 — increment loaded at reset.
- `OVS`, 16 — oversample ratio; power of two, ≥2.
- `clk` input 1 — system clock.
- `rst` input 1 — asynchronous, active-low reset.
- `en` input 1 — count enable.
- `resync` input 1 — single-cycle request to realign the bit phase to mid-bit.
- `inc_wr` input 1 — write strobe for a new increment.
- `inc_data` input ACC_WIDTH — new increment value.
- `os_tick` output 1 — oversample tick, one-cycle pulse.
- `bit_tick` output 1 — bit tick, one-cycle pulse, coincident with an `os_tick`.
- `os_cnt` output $clog2(OVS) — oversample phase within the current bit.
- `inc_cur` output ACC_WIDTH — increment currently in use.
- `inc_pend` output 1 — a written increment is waiting to be committed.

## Operation
- **Reset values (rst=0, async):**
  - `acc` = 0
  - `os_tick` = 0, `bit_tick` = 0
  - `os_cnt` = 0
  - `inc_cur` = INC_DEFAULT
  - `inc_pend` = 0
  - pending register = INC_DEFAULT
- **Priority per edge:** reset > resync > en.
- **en=1, resync=0:** `{carry, acc} <= acc + inc_cur`, computed at ACC_WIDTH+1 bits; `os_tick <= carry`.
- **On carry:**
  - `os_cnt <= os_cnt + 1`, wrapping modulo OVS.
  - `bit_tick <= (os_cnt == OVS-1)`.
- **en=0, resync=0:** `acc` and `os_cnt` hold; `os_tick` and `bit_tick` are 0. `inc_wr` is still accepted.
- **resync=1:**
  - `acc <= 0`; `os_cnt <= OVS/2`.
  - `os_tick` and `bit_tick` are 0 that cycle, regardless of `en`.
  - First `bit_tick` occurs after OVS/2 further oversample ticks (mid-bit sampling point).
- **Increment update:**
  - `inc_wr` captures `inc_data` into the pending register and sets `inc_pend`.
  - Commit event = a carry, or resync: `inc_cur` <= pending value, `inc_pend` <= 0.
  - Increment is never changed between ticks.
- **Boundary conditions:**
  - `inc_wr` while `inc_pend`=1 overwrites the pending value; only the last write is committed.
  - `inc_wr` coincident with a commit event commits the old pending value (if any), and the new data becomes pending (`inc_pend`=1).
  - `inc_wr` coincident with a commit event and no prior pending: nothing is committed; the new data waits for the next event.
  - `inc_cur`=0 stalls tick generation; a pending value then commits only on resync.
  - Accumulator wrap is modular; the fractional remainder is kept, so no drift accumulates.

## Timing
- `os_tick`/`bit_tick` are registered: high for the cycle after the enabled edge whose addition overflowed.
- Tick spacing: ⌈2^ACC_WIDTH/inc⌉ or ⌊2^ACC_WIDTH/inc⌋ enabled cycles; the long-run average is exact.
- `inc_cur` updates on the same edge that raises `os_tick`; the next addition uses the new value.
- Resync-to-first-`os_tick` equals the same interval as from reset with the committed increment.
- Reset deassertion: the first addition happens on the first edge with `rst`=1 and `en`=1.

## Configuration
- **`UART_BAUD_GEN_INC_WR_EN` defined:** the runtime increment path above is present.
- **Not defined:**
  - `inc_cur` is constant INC_DEFAULT.
  - `inc_wr` and `inc_data` are ignored.
  - `inc_pend` is tied 0.
  - No pending register is built.

## Test plan
- **Reset and basic ticks:** ACC_WIDTH=16, OVS=16, default replaced by INC_DEFAULT=16384; release `rst`, hold `en`=1 → `os_tick` pulses every 4 cycles, first after the 4th enabled edge; `bit_tick` every 64 cycles together with `os_tick`; `os_cnt` cycles 0..15.
- **Fractional rate:** inc=30000 → carries after the 3rd and 5th additions (acc 24464, 18928); no missing or double ticks over 10 000 cycles; total `os_tick` count = ⌊10000·30000/65536⌋ = 4577.
- **Resync:** inc=16384; assert `resync` at `os_cnt`=5 → `os_cnt`=8, `acc`=0, no tick that cycle; first `bit_tick` 32 cycles later.
- **Increment update:** inc=16384, write 32768 two cycles after an `os_tick` → `inc_pend`=1 for 2 cycles, commits with the next `os_tick`; `os_tick` then every 2 cycles. Two back-to-back writes (8192, 32768) → only 32768 is committed.
- **Enable and stall:** drop `en` for 10 cycles mid-period → `acc` and `os_cnt` frozen, no ticks; tick resumes exactly after the remaining cycles. Write inc=0 → ticks stop after commit; then `resync` with pending 16384 → ticks resume.
- **Async reset mid-operation:** assert `rst`=0 between edges with `inc_pend`=1 → all outputs return to reset values immediately; `inc_cur`=INC_DEFAULT.
